inst_pc_control: RTL and testbench

Program-counter sequencer for the instruction memory. It drives the fetch PC, sequences through the stored program, and applies the jump target and loop-done status returned by the loop-control block. It owns the run/idle/done state of the instruction engine, honours stall and debug freeze, and reports busy, done and a run-cycle count to the CSR block. It is the counterpart of the loop controller: it consumes `inst_jump`, `inst_jump_addr` and `inst_loop_done`, and produces the PC and enable that the loop controller observes.

---
 rtl/hypercorex_pkg.sv | 14 +
 rtl/sat_counter.sv | 29 ++
 rtl/inst_pc_control.sv | 113 +++++++++++
 tb/tb_inst_pc_control.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/hypercorex_pkg.sv
// Shared types and default widths for the instruction engine.
package hypercorex_pkg;

  // Run state of the instruction engine.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } inst_pc_state_e;

  localparam int unsigned InstMemAddrWidthDef = 32;
  localparam int unsigned CycleCountWidthDef  = 32;

endpackage

// File: rtl/sat_counter.sv
// Saturating counter with synchronous clear and count enable.
module sat_counter #(
  parameter int unsigned Width = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [Width-1:0] count_o
);

  localparam logic [Width-1:0] One = Width'(1);

  logic [Width-1:0] count_reg;

  // Clear wins over enable; the count sticks once it reaches all-ones.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_reg <= '0;
    end else if (clr_i) begin
      count_reg <= '0;
    end else if (en_i && (count_reg != '1)) begin
      count_reg <= count_reg + One;
    end
  end

  assign count_o = count_reg;

endmodule

// File: rtl/inst_pc_control.sv
// Program-counter sequencer: owns the IDLE/RUN/DONE state of the instruction
// engine, steps the fetch PC and applies jumps/done from the loop controller.
module inst_pc_control
  import hypercorex_pkg::*;
#(
  parameter int unsigned InstMemAddrWidth = InstMemAddrWidthDef,
  parameter int unsigned CycleCountWidth  = CycleCountWidthDef
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        clr_i,
  input  logic                        start_i,
  input  logic                        stall_i,
  input  logic                        dbg_en_i,
  input  logic                        dbg_pc_wr_i,
  input  logic [InstMemAddrWidth-1:0] dbg_pc_i,
  input  logic                        inst_loop_en_i,
  input  logic [InstMemAddrWidth-1:0] inst_end_addr_i,
  input  logic                        inst_jump_i,
  input  logic [InstMemAddrWidth-1:0] inst_jump_addr_i,
  input  logic                        inst_loop_done_i,
  output logic [InstMemAddrWidth-1:0] inst_pc_o,
  output logic                        inst_en_o,
  output logic                        inst_busy_o,
  output logic                        inst_done_o,
  output logic [CycleCountWidth-1:0]  inst_cycle_count_o
);

  localparam logic [InstMemAddrWidth-1:0] PcOne = InstMemAddrWidth'(1);

  inst_pc_state_e              state_reg, state_next;
  logic [InstMemAddrWidth-1:0] pc_reg, pc_next;
  logic                        cnt_clr, cnt_en;
  logic                        end_hit;

  // With loop control active the loop controller decides when we are done;
  // otherwise the program ends at the configured last address.
  assign end_hit = inst_loop_en_i ? inst_loop_done_i : (pc_reg == inst_end_addr_i);

  // Next state, next PC and counter controls; clear > debug > stall > normal.
  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    cnt_clr    = 1'b0;
    cnt_en     = 1'b0;
    if (clr_i) begin
      state_next = IDLE;
      pc_next    = '0;
      cnt_clr    = 1'b1;
    end else begin
      unique case (state_reg)
        IDLE, DONE: begin
          // Start is accepted regardless of stall or debug.
          if (start_i) begin
            state_next = RUN;
            pc_next    = '0;
            cnt_clr    = 1'b1;
          end
        end
        RUN: begin
          if (dbg_en_i) begin
            // Frozen: only a debug PC write may move the PC.
            if (dbg_pc_wr_i) pc_next = dbg_pc_i;
          end else begin
            // Stalled cycles still count as run time.
            cnt_en = 1'b1;
            if (!stall_i) begin
              if (end_hit) begin
                state_next = DONE;
              end else if (inst_loop_en_i && inst_jump_i) begin
                pc_next = inst_jump_addr_i;
              end else begin
                pc_next = pc_reg + PcOne;
              end
            end
          end
        end
        default: begin
          state_next = IDLE;
          pc_next    = '0;
        end
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_reg <= IDLE;
    else         state_reg <= state_next;
  end

  // PC register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) pc_reg <= '0;
    else         pc_reg <= pc_next;
  end

  sat_counter #(
    .Width (CycleCountWidth)
  ) u_cycle_counter (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clr_i   (cnt_clr),
    .en_i    (cnt_en),
    .count_o (inst_cycle_count_o)
  );

  assign inst_pc_o   = pc_reg;
  assign inst_en_o   = (state_reg == RUN);
  assign inst_busy_o = (state_reg == RUN);
  assign inst_done_o = (state_reg == DONE);

endmodule

// File: tb/tb_inst_pc_control.sv
// Randomised + directed bench for inst_pc_control with a scoreboard queue.
module tb_inst_pc_control;

  localparam int AW   = 4;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;
  localparam int PMOD = (1 << AW);

  logic          clk;
  logic          rst_n;
  logic          clr, start, stall, dbg_en, dbg_wr;
  logic [AW-1:0] dbg_pc;
  logic          loop_en;
  logic [AW-1:0] end_addr;
  logic          jump;
  logic [AW-1:0] jump_addr;
  logic          loop_done;
  logic [AW-1:0] pc;
  logic          en, busy, done;
  logic [CW-1:0] count;

  inst_pc_control #(
    .InstMemAddrWidth (AW),
    .CycleCountWidth  (CW)
  ) dut (
    .clk_i              (clk),
    .rst_ni             (rst_n),
    .clr_i              (clr),
    .start_i            (start),
    .stall_i            (stall),
    .dbg_en_i           (dbg_en),
    .dbg_pc_wr_i        (dbg_wr),
    .dbg_pc_i           (dbg_pc),
    .inst_loop_en_i     (loop_en),
    .inst_end_addr_i    (end_addr),
    .inst_jump_i        (jump),
    .inst_jump_addr_i   (jump_addr),
    .inst_loop_done_i   (loop_done),
    .inst_pc_o          (pc),
    .inst_en_o          (en),
    .inst_busy_o        (busy),
    .inst_done_o        (done),
    .inst_cycle_count_o (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int pc;
    bit running;
    bit finished;
    int cnt;
  } exp_t;

  exp_t q[$];
  int   tests  = 0;
  int   fails  = 0;
  int   cyc    = 0;

  // Behavioural model: the engine is either running, finished, or neither.
  bit m_running, m_finished;
  int m_pc, m_cnt;

  function automatic void model_reset();
    m_running  = 0;
    m_finished = 0;
    m_pc       = 0;
    m_cnt      = 0;
  endfunction

  function automatic void model_step();
    bit fin;
    if (!rst_n || clr) begin
      model_reset();
    end else if (!m_running) begin
      if (start) begin
        m_running  = 1;
        m_finished = 0;
        m_pc       = 0;
        m_cnt      = 0;
      end
    end else if (dbg_en) begin
      if (dbg_wr) m_pc = int'(dbg_pc);
    end else begin
      m_cnt = (m_cnt + 1 > CMAX) ? CMAX : m_cnt + 1;
      if (!stall) begin
        fin = loop_en ? loop_done : (m_pc == int'(end_addr));
        if (fin) begin
          m_running  = 0;
          m_finished = 1;
        end else if (loop_en && jump) begin
          m_pc = int'(jump_addr);
        end else begin
          m_pc = (m_pc + 1) % PMOD;
        end
      end
    end
  endfunction

  // Apply the currently set inputs for one clock and queue the expected result.
  task automatic step();
    exp_t e;
    model_step();
    e.pc       = m_pc;
    e.running  = m_running;
    e.finished = m_finished;
    e.cnt      = m_cnt;
    q.push_back(e);
    @(negedge clk);
  endtask

  task automatic quiet();
    clr = 0; start = 0; stall = 0; dbg_en = 0; dbg_wr = 0; jump = 0; loop_done = 0;
  endtask

  // Asynchronous reset asserted mid-cycle: outputs must clear without a clock.
  task automatic mid_reset();
    rst_n = 0;
    #1;
    tests++;
    if (pc !== '0 || en !== 0 || busy !== 0 || done !== 0 || count !== '0) begin
      fails++;
      $display("[TB] FAIL async_reset: got pc=%0d en=%0b busy=%0b done=%0b cnt=%0d, want all 0",
               pc, en, busy, done, count);
    end else begin
      $display("[TB] async_reset outputs cleared");
    end
    step();
    rst_n = 1;
  endtask

  // Monitor: one popped expectation per clock, compared just after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        cyc++;
        tests++;
        if (int'(pc) != e.pc || busy !== e.running || en !== e.running ||
            done !== e.finished || int'(count) != e.cnt) begin
          fails++;
          $display("[TB] FAIL cycle %0d: got pc=%0d busy=%0b en=%0b done=%0b cnt=%0d, want pc=%0d busy=%0b en=%0b done=%0b cnt=%0d",
                   cyc, pc, busy, en, done, count, e.pc, e.running, e.running, e.finished, e.cnt);
        end else begin
          $display("[TB] cycle %0d pc=%0d busy=%0b done=%0b cnt=%0d ok", cyc, pc, busy, done, count);
        end
      end
    end
  end

  initial begin
    int jumps;
    rst_n = 0;
    quiet();
    dbg_pc = '0; loop_en = 0; end_addr = '0; jump_addr = '0;
    model_reset();
    @(negedge clk);
    step();
    step();
    rst_n = 1;
    step();

    // Linear run to end address 5.
    loop_en = 0; end_addr = 4'd5;
    start = 1; step(); start = 0;
    for (int i = 0; i < 8; i++) step();

    // Loop path: jump 4 -> 2 three times, then done at 4.
    loop_en = 1; jump_addr = 4'd2; jumps = 0;
    start = 1; step(); start = 0;
    for (int i = 0; i < 20; i++) begin
      jump      = (m_running && m_pc == 4 && jumps < 3);
      loop_done = (m_running && m_pc == 4 && jumps == 3);
      if (jump) jumps++;
      step();
    end
    quiet();

    // Stall at PC=3, debug write PC=10, release.
    loop_en = 0; end_addr = 4'd15;
    start = 1; step(); start = 0;
    for (int i = 0; i < 10 && m_pc != 3; i++) step();
    stall = 1; step(); step(); step(); stall = 0;
    dbg_en = 1; dbg_wr = 1; dbg_pc = 4'd10; step();
    dbg_wr = 0; step(); step();
    dbg_en = 0; step(); step(); step();

    // Jump and done together, then clear with start in DONE.
    loop_en = 1; jump_addr = 4'd1;
    start = 1; step(); start = 0;
    step(); step();
    jump = 1; loop_done = 1; step(); quiet();
    step();
    clr = 1; start = 1; step(); quiet();
    step();

    // PC wrap through 15 -> 0 and counter saturation.
    loop_en = 1;
    start = 1; step(); start = 0;
    for (int i = 0; i < 22; i++) step();

    // Reset mid-run at PC=7, then restart.
    clr = 1; step(); clr = 0;
    loop_en = 0; end_addr = 4'd15;
    start = 1; step(); start = 0;
    for (int i = 0; i < 12 && m_pc != 7; i++) step();
    mid_reset();
    start = 1; step(); start = 0;
    step(); step();

    // Randomised traffic.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        quiet();
        mid_reset();
      end else begin
        clr       = ($urandom_range(0, 49) == 0);
        start     = ($urandom_range(0, 9) == 0);
        stall     = ($urandom_range(0, 4) == 0);
        dbg_en    = ($urandom_range(0, 9) == 0);
        dbg_wr    = $urandom_range(0, 1) == 1;
        dbg_pc    = AW'($urandom_range(0, PMOD - 1));
        if ($urandom_range(0, 19) == 0) loop_en = ~loop_en;
        if ($urandom_range(0, 19) == 0) end_addr = AW'($urandom_range(0, PMOD - 1));
        jump      = ($urandom_range(0, 4) == 0);
        jump_addr = AW'($urandom_range(0, PMOD - 1));
        loop_done = ($urandom_range(0, 19) == 0);
        step();
      end
    end
    quiet();
    step();
    @(posedge clk);
    #2;
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("[TB] FAIL drain: got %0d pending, want 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
